// File: rtl/ec_core_rdc.sv
// ec_core_rdc: reduces a signed-digit operand pair (p, n) to (p - n) mod PRIME.
// One add-PRIME or subtract-PRIME correction is applied per cycle. Completion
// is reported with a one-cycle done pulse. err flags operands that still need
// correcting once MAX_ITER corrections have been spent.
module ec_core_rdc #(
   parameter logic [255:0] PRIME    = 256'hFFFFFFFEFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF00000000FFFFFFFFFFFFFFFF,
   parameter int unsigned  MAX_ITER = 3   // legal range 1..7
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         clr,
   input  logic [255:0] in_p,
   input  logic [255:0] in_n,
   output logic         busy,
   output logic         done,
   output logic         err,
   output logic [255:0] res
);

   typedef enum logic {
      IDLE = 1'b0,
      CORR = 1'b1
   } state_t;

   // Modulus widened to the accumulator width; bit 257 is the sign.
   localparam logic signed [257:0] P_EXT    = $signed({2'b00, PRIME});
   localparam logic [2:0]          ITER_MAX = 3'(MAX_ITER);

   state_t              state;
   logic signed [257:0] acc;
   logic [2:0]          iter;

   logic acc_neg;
   logic acc_ge_p;
   logic iter_ok;

   // Full-width signed range tests on the accumulator, plus the iteration budget.
   always_comb begin
      acc_neg  = 1'b0;
      acc_ge_p = 1'b0;
      iter_ok  = 1'b0;
      acc_neg  = (acc < 0);
      acc_ge_p = (acc >= P_EXT);
      iter_ok  = (iter < ITER_MAX);
   end

   assign busy = (state == CORR);

   // Control and datapath: load the difference, correct it, then report the result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         acc   <= '0;
         iter  <= '0;
         res   <= '0;
         done  <= 1'b0;
         err   <= 1'b0;
      end else if (clr) begin
         state <= IDLE;
         acc   <= '0;
         iter  <= '0;
         res   <= '0;
         done  <= 1'b0;
         err   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  acc   <= $signed({2'b00, in_p}) - $signed({2'b00, in_n});
                  iter  <= '0;
                  state <= CORR;
               end
            end
            CORR: begin
               if (acc_neg && iter_ok) begin
                  acc  <= acc + P_EXT;
                  iter <= iter + 3'd1;
               end else if (acc_ge_p && iter_ok) begin
                  acc  <= acc - P_EXT;
                  iter <= iter + 3'd1;
               end else if (!acc_neg && !acc_ge_p) begin
                  res   <= acc[255:0];
                  done  <= 1'b1;
                  err   <= 1'b0;
                  state <= IDLE;
               end else begin
                  // The budget is spent and the value is still out of range.
                  res   <= '0;
                  done  <= 1'b1;
                  err   <= 1'b1;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ec_core_rdc.sv
// tb_ec_core_rdc: directed and random operands for ec_core_rdc. Two instances
// are exercised: one with the default MAX_ITER and one with MAX_ITER=1.
module tb_ec_core_rdc;

   localparam logic [255:0] PRIME = 256'hFFFFFFFEFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF00000000FFFFFFFFFFFFFFFF;
   localparam logic [255:0] ONES  = '1;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic         clr;
   logic [255:0] in_p;
   logic [255:0] in_n;

   logic         busy0, done0, err0;
   logic [255:0] res0;
   logic         busy1, done1, err1;
   logic [255:0] res1;

   int vectors     = 0;
   int miscompares = 0;

   // Expected results for the current operation (default instance / MAX_ITER=1 instance).
   logic [255:0] er0, er1;
   logic         ee0, ee1;
   int           lat0, lat1;

   always #5 clk = ~clk;

   ec_core_rdc dut (
      .clk(clk), .rst_n(rst_n), .start(start), .clr(clr),
      .in_p(in_p), .in_n(in_n),
      .busy(busy0), .done(done0), .err(err0), .res(res0)
   );

   ec_core_rdc #(.MAX_ITER(1)) dut_m1 (
      .clk(clk), .rst_n(rst_n), .start(start), .clr(clr),
      .in_p(in_p), .in_n(in_n),
      .busy(busy1), .done(done1), .err(err1), .res(res1)
   );

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_b(input string tag, input logic obs, input logic exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Reference: the number of corrections is how many multiples of PRIME separate
   // p-n from [0, PRIME). done comes 1+N edges after the start edge, or 1+mi edges
   // after it when N exceeds the budget mi.
   task automatic model(input logic [255:0] p, input logic [255:0] n, input int mi,
                        output logic [255:0] r, output logic e, output int lat);
      logic signed [259:0] d, pp, q, rr;
      int                  nc;
      d  = $signed({4'b0, p}) - $signed({4'b0, n});
      pp = $signed({4'b0, PRIME});
      if (d < 0) begin
         q  = (-d + pp - 260'sd1) / pp;
         rr = d + q * pp;
      end else begin
         q  = d / pp;
         rr = d - q * pp;
      end
      nc = int'(q);
      if (nc > mi) begin
         r   = '0;
         e   = 1'b1;
         lat = 1 + mi;
      end else begin
         r   = rr[255:0];
         e   = 1'b0;
         lat = 1 + nc;
      end
   endtask

   function automatic logic [255:0] rnd256();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic set_op(input logic [255:0] p, input logic [255:0] n);
      in_p  = p;
      in_n  = n;
      start = 1'b1;
      model(p, n, 3, er0, ee0, lat0);
      model(p, n, 1, er1, ee1, lat1);
   endtask

   // Leaves the bench at the falling edge right after the start edge E0.
   task automatic issue(input logic [255:0] p, input logic [255:0] n);
      @(negedge clk);
      set_op(p, n);
      @(posedge clk);
      @(negedge clk);
   endtask

   // Checks both instances cycle by cycle, starting at the falling edge after E0.
   // disturb: present a different request one cycle after E0, which must be ignored.
   // chain: issue (cp, cn) in the cycle where done is high, and return at that point.
   task automatic track(input bit disturb, input bit chain,
                        input logic [255:0] cp, input logic [255:0] cn);
      chk_b("busy_after_start", busy0, 1'b1);
      chk_b("busy_after_start_m1", busy1, 1'b1);
      if (disturb) begin
         start = 1'b1;
         in_p  = cp;
         in_n  = cn;
      end else begin
         start = 1'b0;
      end
      for (int k = 1; k <= 5; k++) begin
         @(posedge clk);
         @(negedge clk);
         start = 1'b0;
         chk_b("done", done0, k == lat0);
         chk_b("busy", busy0, k < lat0);
         if (k == lat0) begin
            chk("res", res0, er0);
            chk_b("err", err0, ee0);
         end
         chk_b("done_m1", done1, k == lat1);
         chk_b("busy_m1", busy1, k < lat1);
         if (k == lat1) begin
            chk("res_m1", res1, er1);
            chk_b("err_m1", err1, ee1);
         end
         if (chain && k >= lat0 && k >= lat1) begin
            set_op(cp, cn);
            return;
         end
      end
   endtask

   initial begin
      logic [255:0] p, n;
      rst_n = 1'b0;
      start = 1'b0;
      clr   = 1'b0;
      in_p  = '0;
      in_n  = '0;
      #1;
      chk_b("rst_busy", busy0, 1'b0);
      chk_b("rst_done", done0, 1'b0);
      chk_b("rst_err", err0, 1'b0);
      chk("rst_res", res0, '0);
      chk_b("rst_busy_m1", busy1, 1'b0);
      chk("rst_res_m1", res1, '0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Directed cases
      issue(256'd5, 256'd3);       track(1'b0, 1'b0, '0, '0);
      issue(256'd0, 256'd1);       track(1'b0, 1'b0, '0, '0);
      issue(ONES, 256'd0);         track(1'b0, 1'b0, '0, '0);
      issue(256'd0, ONES);         track(1'b0, 1'b0, '0, '0);
      issue(PRIME, 256'd0);        track(1'b0, 1'b0, '0, '0);
      issue(256'd0, PRIME);        track(1'b0, 1'b0, '0, '0);

      // A second request one cycle after E0 is ignored
      issue(256'd0, ONES);         track(1'b1, 1'b0, 256'd77, 256'd1);
      issue(256'd5, 256'd3);       track(1'b1, 1'b0, ONES, 256'd0);

      // A new request in the done cycle is accepted
      issue(256'd0, 256'd1);       track(1'b0, 1'b1, 256'd9, 256'd4);
      @(posedge clk); @(negedge clk);
      track(1'b0, 1'b1, 256'd0, ONES);
      @(posedge clk); @(negedge clk);
      track(1'b0, 1'b0, '0, '0);

      // clr at E0+1 aborts with no done pulse
      issue(256'd0, ONES);
      start = 1'b0;
      clr   = 1'b1;
      @(posedge clk); @(negedge clk);
      clr = 1'b0;
      chk_b("clr_busy", busy0, 1'b0);
      chk_b("clr_done", done0, 1'b0);
      chk_b("clr_err", err0, 1'b0);
      chk("clr_res", res0, '0);
      chk_b("clr_busy_m1", busy1, 1'b0);
      chk("clr_res_m1", res1, '0);
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); @(negedge clk);
         chk_b("clr_no_done", done0, 1'b0);
         chk_b("clr_no_done_m1", done1, 1'b0);
      end

      // rst_n low in the middle of CORR returns everything to reset values at once
      issue(ONES, 256'd0);         track(1'b0, 1'b0, '0, '0);
      issue(256'd0, ONES);
      start = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk_b("arst_busy", busy0, 1'b0);
      chk_b("arst_done", done0, 1'b0);
      chk_b("arst_err", err0, 1'b0);
      chk("arst_res", res0, '0);
      chk_b("arst_busy_m1", busy1, 1'b0);
      chk_b("arst_err_m1", err1, 1'b0);
      chk("arst_res_m1", res1, '0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); @(negedge clk);
         chk_b("arst_no_done", done0, 1'b0);
         chk_b("arst_no_done_m1", done1, 1'b0);
      end

      // Random operands
      for (int t = 0; t < 24; t++) begin
         case ($urandom_range(0, 3))
            0: begin p = rnd256(); n = rnd256(); end
            1: begin p = rnd256(); n = 256'(32'($urandom)); end
            2: begin p = 256'(32'($urandom)); n = ONES - 256'(32'($urandom)); end
            default: begin p = PRIME + 256'($urandom_range(0, 3)); n = 256'($urandom_range(0, 5)); end
         endcase
         issue(p, n);
         track(1'b0, 1'b0, '0, '0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
